// File: rtl/tpu_pkg.sv
// Shared TPU types for the input setup stage: default array geometry,
// the activation element type and the setup FSM state encoding.
package tpu_pkg;

    localparam int N_DEF      = 2;
    localparam int DATA_W_DEF = 8;

    typedef logic [DATA_W_DEF-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        STREAM = 2'd2
    } setup_state_t;

endpackage

// File: rtl/input_setup_if.sv
// Tile load / stream handshake between the UB-side controller (master)
// and the input setup stage (slave).
interface input_setup_if #(
    parameter int N      = 2,
    parameter int DATA_W = 8
);
    logic                  load_tile;
    logic [N*N*DATA_W-1:0] tile_in;
    logic                  start;
    logic [N*DATA_W-1:0]   row_data;
    logic [N-1:0]          row_valid;
    logic                  tile_held;
    logic                  busy;
    logic                  done;
    logic                  load_drop;

    modport master (
        output load_tile, tile_in, start,
        input  row_data, row_valid, tile_held, busy, done, load_drop
    );

    modport slave (
        input  load_tile, tile_in, start,
        output row_data, row_valid, tile_held, busy, done, load_drop
    );
endinterface

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying {valid, data} for one array row;
// depth 0 is a plain pass-through.
module skew_delay_line #(
    parameter int DEPTH = 0,
    parameter int W     = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] d_out
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign d_out = d_in;
        end else begin : g_pipe
            logic [W-1:0] pipe_q [DEPTH];

            // Shift one stage per cycle; reset drains every stage to invalid/zero.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= d_in;
                    for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign d_out = pipe_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/input_setup.sv
// Captures an NxN activation tile and replays it diagonally skewed to the
// systolic array west edge. Optional shadow tile: INPUT_SETUP_DOUBLE_BUF_EN.
module input_setup
    import tpu_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input_setup_if.slave       bus
);

    localparam int STEP_W = (2*N-1 > 1) ? $clog2(2*N-1) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2*N-2);

    setup_state_t              state_q, state_d;
    logic [STEP_W-1:0]         step_q, step_d;
    logic [N*N*DATA_W-1:0]     tile_q, tile_d;
    logic [N-1:0]              feed_valid_q, feed_valid_d;
    logic [N*DATA_W-1:0]       feed_data_q, feed_data_d;
    logic                      done_q, done_d;
    logic                      load_drop_q, load_drop_d;
    logic                      tile_held_q, busy_q;
    logic                      refused_load_s;
`ifdef INPUT_SETUP_DOUBLE_BUF_EN
    logic [N*N*DATA_W-1:0]     shadow_q, shadow_d;
    logic                      shadow_full_q, shadow_full_d;
`endif

    function automatic logic [N*DATA_W-1:0] column(input logic [N*N*DATA_W-1:0] t,
                                                   input int col);
        logic [N*DATA_W-1:0] c;
        c = '0;
        for (int r = 0; r < N; r++) c[r*DATA_W +: DATA_W] = t[(r*N+col)*DATA_W +: DATA_W];
        return c;
    endfunction

    // Next-state logic: the feed stage presents unskewed column s at step s < N.
    always_comb begin
        state_d        = state_q;
        step_d         = step_q;
        tile_d         = tile_q;
        done_d         = 1'b0;
        load_drop_d    = 1'b0;
        feed_valid_d   = '0;
        feed_data_d    = '0;
        refused_load_s = 1'b0;
`ifdef INPUT_SETUP_DOUBLE_BUF_EN
        shadow_d       = shadow_q;
        shadow_full_d  = shadow_full_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.load_tile) begin
                    tile_d  = bus.tile_in;
                    state_d = HELD;
                end else begin
                    state_d = IDLE;
                end
            end
            HELD: begin
                if (bus.start) begin
                    state_d        = STREAM;
                    step_d         = '0;
                    feed_valid_d   = '1;
                    feed_data_d    = column(tile_q, 0);
                    refused_load_s = bus.load_tile;
                end else if (bus.load_tile) begin
                    tile_d = bus.tile_in;
                end else begin
                    state_d = HELD;
                end
            end
            STREAM: begin
                refused_load_s = bus.load_tile;
                if (step_q == LAST_STEP) begin
                    state_d = IDLE;
                    step_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    step_d = step_q + STEP_W'(1);
                    if (int'(step_d) < N) begin
                        feed_valid_d = '1;
                        feed_data_d  = column(tile_q, int'(step_d));
                    end else begin
                        feed_valid_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef INPUT_SETUP_DOUBLE_BUF_EN
        // A load arriving on the final step lands in the shadow and is promoted at once.
        if (refused_load_s) begin
            shadow_d      = bus.tile_in;
            shadow_full_d = 1'b1;
        end else begin
            shadow_d = shadow_d;
        end
        if (done_d && shadow_full_d) begin
            tile_d        = shadow_d;
            shadow_full_d = 1'b0;
            state_d       = HELD;
        end else begin
            shadow_full_d = shadow_full_d;
        end
`else
        load_drop_d = refused_load_s;
`endif
    end

    // State, tile storage and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            step_q        <= '0;
            tile_q        <= '0;
            feed_valid_q  <= '0;
            feed_data_q   <= '0;
            done_q        <= 1'b0;
            load_drop_q   <= 1'b0;
            tile_held_q   <= 1'b0;
            busy_q        <= 1'b0;
`ifdef INPUT_SETUP_DOUBLE_BUF_EN
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            step_q        <= step_d;
            tile_q        <= tile_d;
            feed_valid_q  <= feed_valid_d;
            feed_data_q   <= feed_data_d;
            done_q        <= done_d;
            load_drop_q   <= load_drop_d;
            tile_held_q   <= (state_d == HELD);
            busy_q        <= (state_d == STREAM);
`ifdef INPUT_SETUP_DOUBLE_BUF_EN
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
`endif
        end
    end

    logic [N-1:0]        row_valid_s;
    logic [N*DATA_W-1:0] row_data_s;

    generate
        for (genvar r = 0; r < N; r++) begin : g_row
            logic [DATA_W:0] row_bits_s;
            skew_delay_line #(.DEPTH(r), .W(DATA_W+1)) u_delay (
                .clk   (clk),
                .reset (reset),
                .d_in  ({feed_valid_q[r], feed_data_q[r*DATA_W +: DATA_W]}),
                .d_out (row_bits_s)
            );
            assign row_valid_s[r]                  = row_bits_s[DATA_W];
            assign row_data_s[r*DATA_W +: DATA_W]  = row_bits_s[DATA_W-1:0];
        end
    endgenerate

    assign bus.row_valid = row_valid_s;
    assign bus.row_data  = row_data_s;
    assign bus.tile_held = tile_held_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.load_drop = load_drop_q;

endmodule

// File: tb/tb_input_setup.sv
// Directed table-driven bench for input_setup (N=2, DATA_W=8); follows
// INPUT_SETUP_DOUBLE_BUF_EN so expectations track the build variant.
module tb_input_setup;

`ifdef INPUT_SETUP_DOUBLE_BUF_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif
    localparam logic [31:0] TA = 32'h04030201;
    localparam logic [31:0] TB = 32'h08070605;
    localparam logic [31:0] TC = 32'h0c0b0a09;

    typedef struct {
        logic        load;
        logic [31:0] tile;
        logic        start;
        logic [1:0]  valid;
        logic [15:0] data;
        logic        held;
        logic        busy;
        logic        done;
        logic        drop;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[$];

    input_setup_if #(.N(2), .DATA_W(8)) bus ();

    input_setup #(.N(2), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic add(input logic ld, input logic [31:0] t, input logic st,
                       input logic [1:0] v, input logic [15:0] d,
                       input logic h, input logic b, input logic dn, input logic dr);
        vec_t e;
        e.load = ld; e.tile = t; e.start = st; e.valid = v; e.data = d;
        e.held = h; e.busy = b; e.done = dn; e.drop = dr;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input vec_t e);
        logic [21:0] act, exp;
        act = {bus.row_valid, bus.row_data, bus.tile_held, bus.busy, bus.done, bus.load_drop};
        exp = {e.valid, e.data, e.held, e.busy, e.done, e.drop};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got v=%b d=%h held=%b busy=%b done=%b drop=%b want v=%b d=%h held=%b busy=%b done=%b drop=%b",
                     name, act[21:20], act[19:4], act[3], act[2], act[1], act[0],
                     exp[21:20], exp[19:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // One cycle: check this cycle's outputs, then drive this cycle's inputs.
    task automatic cyc(input string name, input vec_t e);
        @(posedge clk);
        #1;
        check(name, e);
        bus.load_tile = e.load;
        bus.tile_in   = e.tile;
        bus.start     = e.start;
    endtask

    task automatic stream_rows(input logic [31:0] t);
        add(1'b0, 32'h0, 1'b0, 2'b01, {8'h00, t[7:0]},   1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b0, 2'b11, {t[23:16], t[15:8]}, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b0, 2'b10, {t[31:24], 8'h00}, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t z;
        vec_t e;
        bus.load_tile = 1'b0;
        bus.tile_in   = '0;
        bus.start     = 1'b0;
        z = '{load: 1'b0, tile: 32'h0, start: 1'b0, valid: 2'b00, data: 16'h0,
              held: 1'b0, busy: 1'b0, done: 1'b0, drop: 1'b0};

        // Basic: load c0, start c2, operands c3..c5, done c6
        add(1'b1, TA, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b1, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b0, 2'b01, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b0, 2'b11, 16'h0302, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b0, 2'b10, 16'h0400, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        // Start in IDLE is ignored
        add(1'b0, 32'h0, 1'b1, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        // HELD overwrite: load A, load B, start -> B streams
        add(1'b1, TA, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, TB, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b1, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        stream_rows(TB);
        add(1'b0, 32'h0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        // Load B during stream of A
        add(1'b1, TA, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b1, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b1, TB, 1'b0, 2'b01, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b0, 2'b11, 16'h0302, 1'b0, 1'b1, 1'b0, !DB);
        add(1'b0, 32'h0, 1'b0, 2'b10, 16'h0400, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'h0, DB,  2'b00, 16'h0000, DB,   1'b0, 1'b1, 1'b0);
        if (DB) begin
            stream_rows(TB);
            add(1'b0, 32'h0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        add(1'b0, 32'h0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        // HELD with load C + start together: A streams
        add(1'b1, TA, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, TC, 1'b1, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b0, 2'b01, 16'h0001, 1'b0, 1'b1, 1'b0, !DB);
        add(1'b0, 32'h0, 1'b0, 2'b11, 16'h0302, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b0, 2'b10, 16'h0400, 1'b0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 32'h0, DB,  2'b00, 16'h0000, DB,   1'b0, 1'b1, 1'b0);
        if (DB) begin
            stream_rows(TC);
            add(1'b0, 32'h0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        add(1'b0, 32'h0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        // Back-to-back: reload in the done cycle, start next cycle
        add(1'b1, TC, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 32'h0, 1'b1, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        stream_rows(TC);
        add(1'b1, TB, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'h0, 1'b1, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        stream_rows(TB);
        add(1'b0, 32'h0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 32'h0, 1'b0, 2'b00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", z);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) cyc($sformatf("vec%0d", i), vecs[i]);

        // Reset asserted while step 1 is on the outputs
        e = z; e.load = 1'b1; e.tile = TA;
        cyc("rst_load", e);
        e = z; e.held = 1'b1; e.start = 1'b1;
        cyc("rst_held", e);
        e = z; e.valid = 2'b01; e.data = 16'h0001; e.busy = 1'b1;
        cyc("rst_step0", e);
        e = z; e.valid = 2'b11; e.data = 16'h0302; e.busy = 1'b1;
        cyc("rst_step1", e);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_cleared", z);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc($sformatf("rst_quiet%0d", i), z);
        e = z; e.load = 1'b1; e.tile = TC;
        cyc("post_rst_load", e);
        e = z; e.held = 1'b1; e.start = 1'b1;
        cyc("post_rst_held", e);
        e = z; e.valid = 2'b01; e.data = 16'h0009; e.busy = 1'b1;
        cyc("post_rst_s0", e);
        e = z; e.valid = 2'b11; e.data = 16'h0b0a; e.busy = 1'b1;
        cyc("post_rst_s1", e);
        e = z; e.valid = 2'b10; e.data = 16'h0c00; e.busy = 1'b1;
        cyc("post_rst_s2", e);
        e = z; e.done = 1'b1;
        cyc("post_rst_done", e);
        cyc("post_rst_idle", z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
